// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between message sources.
// Fetches bytes by index from the owner and runs the send/done handshake.
module uart_msg_arbiter #(
  parameter int N_REQ       = 2,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   tx_enable,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*IDX_W-1:0] req_len,
  input  logic [N_REQ*8-1:0]     req_data,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       byte_idx,
  output logic [N_REQ-1:0]       msg_done,
  output logic [N_REQ-1:0]       msg_err,
  output logic [7:0]             uart_data,
  output logic                   uart_send,
  input  logic                   uart_busy,
  input  logic                   uart_done,
  output logic                   active
);

  localparam int WW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } state_t;

  state_t state, state_n;

  logic [WW-1:0]    win, win_n;
  logic [WW-1:0]    last, last_n;
  logic [WW-1:0]    pick;
  logic [WW:0]      rr_s;
  logic             found;
  logic [IDX_W-1:0] len_q, len_n;
  logic [IDX_W-1:0] idx_n;
  logic [TW-1:0]    cnt, cnt_n;
  logic [N_REQ-1:0] grant_n, done_n, err_n, win_oh;
  logic [7:0]       data_n;
  logic             send_n, active_n;

  assign win_oh = N_REQ'(1) << win;

  // First requester above the last owner, wrapping, so the
  // source that just finished is considered last.
  always_comb begin
    pick  = last;
    found = 1'b0;
    rr_s  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_s = {1'b0, last} + (WW + 1)'(i);
      if (rr_s >= (WW + 1)'(N_REQ)) begin
        rr_s = rr_s - (WW + 1)'(N_REQ);
      end
      if (!found && req[rr_s[WW-1:0]]) begin
        found = 1'b1;
        pick  = rr_s[WW-1:0];
      end
    end
  end

  always_comb begin
    state_n  = state;
    win_n    = win;
    last_n   = last;
    len_n    = len_q;
    idx_n    = byte_idx;
    cnt_n    = cnt;
    grant_n  = grant;
    active_n = active;
    data_n   = uart_data;
    send_n   = 1'b0;
    done_n   = '0;
    err_n    = '0;
    unique case (state)
      IDLE: begin
        if (tx_enable && found && !uart_busy) begin
          win_n    = pick;
          grant_n  = N_REQ'(1) << pick;
          len_n    = req_len[pick*IDX_W +: IDX_W];
          idx_n    = '0;
          active_n = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          done_n   = win_oh;
          grant_n  = '0;
          active_n = 1'b0;
          last_n   = win;
          state_n  = IDLE;
        end else begin
          state_n = SEND;
        end
      end
      SEND: begin
        data_n  = req_data[win*8 +: 8];
        send_n  = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (uart_done) begin
          if (byte_idx == len_q - IDX_W'(1)) begin
            done_n   = win_oh;
            grant_n  = '0;
            active_n = 1'b0;
            last_n   = win;
            state_n  = IDLE;
          end else begin
            idx_n   = byte_idx + IDX_W'(1);
            state_n = LOAD;
          end
        end else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
          err_n    = win_oh;
          grant_n  = '0;
          active_n = 1'b0;
          last_n   = win;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      win       <= '0;
      last      <= WW'(N_REQ - 1);
      len_q     <= '0;
      byte_idx  <= '0;
      cnt       <= '0;
      grant     <= '0;
      active    <= 1'b0;
      uart_data <= '0;
      uart_send <= 1'b0;
      msg_done  <= '0;
      msg_err   <= '0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      last      <= last_n;
      len_q     <= len_n;
      byte_idx  <= idx_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      active    <= active_n;
      uart_data <= data_n;
      uart_send <= send_n;
      msg_done  <= done_n;
      msg_err   <= err_n;
    end
  end

endmodule
